// File: rtl/fci_pkg.sv
// fci_pkg
// Shared definitions for the FCI receiver:
//   - FCI_S mux-select encodings driven towards the CPLD
//   - receiver FSM state enum
//   - decoded bus-cycle record handed to the core
package fci_pkg;

    // CPLD mux select: which ZX-bus field the CPLD presents on FCI_I
    localparam logic [1:0] FCI_ZAL = 2'd0;  // ZA[7:0]
    localparam logic [1:0] FCI_ZAH = 2'd1;  // ZA[15:8]
    localparam logic [1:0] FCI_ZD  = 2'd2;  // ZD
    localparam logic [1:0] FCI_ZC  = 2'd3;  // control (unused by the receiver)

    // Byte returned to the CPU when the core never answers a read
    localparam logic [7:0] RD_DEFAULT = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AL,
        ST_AH,
        ST_DAT,
        ST_ISSUE,
        ST_RWAIT,
        ST_RDRV,
        ST_END
    } fci_state_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        we;
        logic        io;
    } fci_req_t;

endpackage

// File: rtl/fci_strobe_sync.sv
// fci_strobe_sync
// Two-flop synchronizer for the four active-low ZX-bus strobes.
// Flops reset high so every strobe reads inactive out of reset.
// Ports:
//   CLK50       in   system clock
//   RST         in   async active-high reset
//   strb_n      in   raw strobes {IORQ_N, MRQ_N, WR_N, RD_N}
//   strb_sync_n out  synchronized strobes, same order
module fci_strobe_sync (
    input  logic       CLK50,
    input  logic       RST,
    input  logic [3:0] strb_n,
    output logic [3:0] strb_sync_n
);

    logic [3:0] meta_n;

    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            meta_n      <= '1;
            strb_sync_n <= '1;
        end else begin
            meta_n      <= strb_n;
            strb_sync_n <= meta_n;
        end
    end

endmodule

// File: rtl/fci_receiver.sv
// fci_receiver
// Decodes ZX-bus cycles presented by the CPLD over the multiplexed FCI bus.
// The address low/high bytes and write data are fetched one at a time by
// steering FCI_S, then a single req pulse hands the cycle to the core. Reads
// wait for rd_valid (or time out to 8'hFF) and drive the byte back on FCI_O.
// Ports:
//   CLK50, RST                       clock, async active-high reset
//   FRD_N, FWR_N, FMRQ_N, FIORQ_N    raw ZX strobes (async to CLK50)
//   FCI_I / FCI_O / FCI_OE           FCI bus in, out, output enable
//   FCI_S                            CPLD mux select
//   FDIR                             1 = CPLD->FPGA, 0 = FPGA->CPLD
//   req, req_addr/wdata/we/io        decoded cycle to the core
//   rd_data, rd_valid                core read response
//   abort_cnt                        saturating count of aborted cycles
module fci_receiver
    import fci_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int RD_TMO = 15
) (
    input  logic        CLK50,
    input  logic        RST,
    input  logic        FRD_N,
    input  logic        FWR_N,
    input  logic        FMRQ_N,
    input  logic        FIORQ_N,
    input  logic [7:0]  FCI_I,
    output logic [7:0]  FCI_O,
    output logic        FCI_OE,
    output logic [1:0]  FCI_S,
    output logic        FDIR,
    output logic        req,
    output logic [15:0] req_addr,
    output logic [7:0]  req_wdata,
    output logic        req_we,
    output logic        req_io,
    input  logic [7:0]  rd_data,
    input  logic        rd_valid,
    output logic [7:0]  abort_cnt
);

    localparam int CMAX = (SETTLE > RD_TMO) ? SETTLE : RD_TMO;
    localparam int CW   = ($clog2(CMAX + 1) < 1) ? 1 : $clog2(CMAX + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE);
    localparam logic [CW-1:0] TMO_LAST    = CW'(RD_TMO - 1);

    logic [3:0] strb_n;
    logic       rd_n, wr_n, mrq_n, iorq_n;
    logic       cycle, cyc_q, all_hi, abort_now, rd_take;
    logic [7:0] rd_byte;

    fci_state_e state;
    logic [CW-1:0] cnt;
    logic [1:0]    drv_ph;
    logic [15:0]   cur_addr;
    logic          cur_we, cur_io;
    fci_req_t      req_f;

    fci_strobe_sync u_sync (
        .CLK50       (CLK50),
        .RST         (RST),
        .strb_n      ({FIORQ_N, FMRQ_N, FWR_N, FRD_N}),
        .strb_sync_n (strb_n)
    );

    assign {iorq_n, mrq_n, wr_n, rd_n} = strb_n;
    assign cycle  = (!rd_n || !wr_n) && (!mrq_n || !iorq_n);
    assign all_hi = &strb_n;

    // Strobe loss while still collecting address/data kills the cycle. Once in
    // ISSUE the req is already on the wire, so the cycle is committed.
    assign abort_now = !cycle && (state inside {ST_AL, ST_AH, ST_DAT});

    // rd_valid wins over the timeout when both land on the last wait cycle
    assign rd_take = rd_valid || (state == ST_RWAIT && cnt == TMO_LAST);
    assign rd_byte = rd_valid ? rd_data : RD_DEFAULT;

    assign req_addr  = req_f.addr;
    assign req_wdata = req_f.wdata;
    assign req_we    = req_f.we;
    assign req_io    = req_f.io;

    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            drv_ph    <= '0;
            cyc_q     <= 1'b0;
            cur_addr  <= '0;
            cur_we    <= 1'b0;
            cur_io    <= 1'b0;
            req_f     <= '0;
            req       <= 1'b0;
            FCI_S     <= FCI_ZAL;
            FDIR      <= 1'b1;
            FCI_OE    <= 1'b0;
            FCI_O     <= '0;
            abort_cnt <= '0;
        end else begin
            cyc_q <= cycle;
            req   <= 1'b0;
            if (abort_now) begin
                state <= ST_IDLE;
                FCI_S <= FCI_ZAL;
                if (abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        FCI_S  <= FCI_ZAL;
                        FDIR   <= 1'b1;
                        FCI_OE <= 1'b0;
                        // Edge-detect so a strobe left low never re-triggers
                        if (cycle && !cyc_q) begin
                            cur_we <= !wr_n;
                            cur_io <= !iorq_n;
                            cnt    <= '0;
                            state  <= ST_AL;
                        end
                    end
                    ST_AL: begin
                        if (cnt == SETTLE_LAST) begin
                            cur_addr[7:0] <= FCI_I;
                            FCI_S         <= FCI_ZAH;
                            cnt           <= '0;
                            state         <= ST_AH;
                        end else cnt <= cnt + 1'b1;
                    end
                    ST_AH: begin
                        if (cnt == SETTLE_LAST) begin
                            cur_addr[15:8] <= FCI_I;
                            cnt            <= '0;
                            if (cur_we) begin
                                FCI_S <= FCI_ZD;
                                state <= ST_DAT;
                            end else begin
                                // Assemble fields directly so req lands in ISSUE
                                req   <= 1'b1;
                                req_f <= '{addr: {FCI_I, cur_addr[7:0]}, wdata: 8'h00,
                                           we: 1'b0, io: cur_io};
                                state <= ST_ISSUE;
                            end
                        end else cnt <= cnt + 1'b1;
                    end
                    ST_DAT: begin
                        if (cnt == SETTLE_LAST) begin
                            req   <= 1'b1;
                            req_f <= '{addr: cur_addr, wdata: FCI_I, we: 1'b1, io: cur_io};
                            FCI_S <= FCI_ZAL;
                            cnt   <= '0;
                            state <= ST_ISSUE;
                        end else cnt <= cnt + 1'b1;
                    end
                    ST_ISSUE: begin
                        cnt <= '0;
                        if (cur_we) state <= ST_END;
                        else if (rd_valid) begin
                            FCI_O  <= rd_data;
                            FDIR   <= 1'b0;
                            drv_ph <= '0;
                            state  <= ST_RDRV;
                        end else state <= ST_RWAIT;
                    end
                    ST_RWAIT: begin
                        if (!cycle) begin
                            FCI_S <= FCI_ZAL;
                            state <= ST_IDLE;
                        end else if (rd_take) begin
                            FCI_O  <= rd_byte;
                            FDIR   <= 1'b0;
                            drv_ph <= '0;
                            state  <= ST_RDRV;
                        end else cnt <= cnt + 1'b1;
                    end
                    ST_RDRV: begin
                        // ph0: turn bus around, ph1: drive, ph2: release direction
                        case (drv_ph)
                            2'd0: begin
                                if (rd_n) drv_ph <= 2'd2;
                                else begin
                                    FCI_OE <= 1'b1;
                                    drv_ph <= 2'd1;
                                end
                            end
                            2'd1: begin
                                if (rd_n) begin
                                    FCI_OE <= 1'b0;
                                    drv_ph <= 2'd2;
                                end
                            end
                            default: begin
                                FDIR  <= 1'b1;
                                FCI_S <= FCI_ZAL;
                                state <= ST_END;
                            end
                        endcase
                    end
                    ST_END: begin
                        FCI_S <= FCI_ZAL;
                        if (all_hi) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fci_receiver.sv
module tb_fci_receiver;

    localparam int SETTLE = 2;
    localparam int RD_TMO = 15;
    localparam int LAT_WR = 3 * (SETTLE + 1) + 3;
    localparam int LAT_RD = 2 * (SETTLE + 1) + 3;

    logic        CLK50 = 1'b0;
    logic        RST = 1'b1;
    logic        FRD_N = 1'b1, FWR_N = 1'b1, FMRQ_N = 1'b1, FIORQ_N = 1'b1;
    logic [7:0]  FCI_I, FCI_O;
    logic        FCI_OE, FDIR, req, req_we, req_io, rd_valid = 1'b0;
    logic [1:0]  FCI_S;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata, rd_data = 8'h00, abort_cnt;

    // CPLD model: presents the field selected by FCI_S
    logic [15:0] bus_addr = 16'h0000;
    logic [7:0]  bus_data = 8'h00;
    assign FCI_I = (FCI_S == 2'd0) ? bus_addr[7:0] :
                   (FCI_S == 2'd1) ? bus_addr[15:8] :
                   (FCI_S == 2'd2) ? bus_data : 8'h00;

    fci_receiver #(.SETTLE(SETTLE), .RD_TMO(RD_TMO)) dut (
        .CLK50(CLK50), .RST(RST),
        .FRD_N(FRD_N), .FWR_N(FWR_N), .FMRQ_N(FMRQ_N), .FIORQ_N(FIORQ_N),
        .FCI_I(FCI_I), .FCI_O(FCI_O), .FCI_OE(FCI_OE), .FCI_S(FCI_S), .FDIR(FDIR),
        .req(req), .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
        .req_io(req_io), .rd_data(rd_data), .rd_valid(rd_valid), .abort_cnt(abort_cnt)
    );

    always #5 CLK50 = ~CLK50;

    int cyc = 0;
    always @(posedge CLK50) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        we;
        logic        io;
        int          t0;
        int          lat;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rd_q[$];
    bit         tmo_q[$];
    int tests = 0, fails = 0;
    int exp_abort = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout, expected DUT event", name);
    endtask

    // ---------------- monitor / scoreboard ----------------
    exp_t m_e;
    int   last_req_cyc = 0, diff;
    logic oe_prev = 1'b0, fdir_prev = 1'b1;
    bit   m_tmo;
    logic [7:0] m_byte;
    int   oe_fall = 0;

    always @(negedge CLK50) begin
        if (RST) begin
            oe_prev = 1'b0; fdir_prev = 1'b1; oe_fall = 0;
        end else begin
            if (req) begin
                last_req_cyc = cyc;
                check("req_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    m_e = exp_q.pop_front();
                    check("req_addr", 32'(req_addr), 32'(m_e.addr));
                    check("req_we", 32'(req_we), 32'(m_e.we));
                    check("req_io", 32'(req_io), 32'(m_e.io));
                    if (m_e.we) check("req_wdata", 32'(req_wdata), 32'(m_e.wdata));
                    diff = cyc - m_e.t0;
                    check("req_latency_in_window",
                          32'(diff >= m_e.lat - 1 && diff <= m_e.lat + 1), 32'd1);
                end
            end
            if (FCI_OE) check("fdir_low_while_oe", 32'(FDIR), 32'd0);
            if (FCI_OE && !oe_prev) begin
                check("fdir_low_before_oe", 32'(fdir_prev), 32'd0);
                check("rd_expected", 32'(rd_q.size() > 0), 32'd1);
                if (rd_q.size() > 0) begin
                    m_byte = rd_q.pop_front();
                    m_tmo  = tmo_q.pop_front();
                    check("fci_o", 32'(FCI_O), 32'(m_byte));
                    if (m_tmo) begin
                        diff = cyc - last_req_cyc;
                        check("tmo_delay_in_window",
                              32'(diff >= RD_TMO && diff <= RD_TMO + 3), 32'd1);
                    end
                end
            end
            if (!FCI_OE && oe_prev) oe_fall = 1;
            else if (oe_fall == 1) begin
                check("fdir_high_after_oe", 32'(FDIR), 32'd1);
                oe_fall = 0;
            end
            oe_prev   = FCI_OE;
            fdir_prev = FDIR;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK50);
            if (req) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("req_timeout");
    endtask

    task automatic release_bus();
        FRD_N = 1'b1; FWR_N = 1'b1; FMRQ_N = 1'b1; FIORQ_N = 1'b1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input bit io, input int gap);
        bit ok;
        bus_addr = a; bus_data = d;
        FWR_N = 1'b0;
        if (io) FIORQ_N = 1'b0; else FMRQ_N = 1'b0;
        exp_q.push_back('{a, d, 1'b1, io, cyc, LAT_WR});
        wait_req(ok);
        repeat (2) @(negedge CLK50);
        release_bus();
        repeat (gap) @(negedge CLK50);
    endtask

    // dly < 0: core never answers
    task automatic bus_read(input logic [15:0] a, input bit io, input int dly, input logic [7:0] d);
        bit ok;
        bus_addr = a;
        FRD_N = 1'b0;
        if (io) FIORQ_N = 1'b0; else FMRQ_N = 1'b0;
        exp_q.push_back('{a, 8'h00, 1'b0, io, cyc, LAT_RD});
        rd_q.push_back((dly >= 0) ? d : 8'hFF);
        tmo_q.push_back(dly < 0);
        wait_req(ok);
        if (ok && dly >= 0) begin
            repeat (dly) @(negedge CLK50);
            rd_data = d; rd_valid = 1'b1;
            @(negedge CLK50);
            rd_valid = 1'b0;
        end
        for (int i = 0; i < RD_TMO + 20 && !FCI_OE; i++) @(negedge CLK50);
        if (!FCI_OE) fail_now("oe_timeout");
        repeat (3) @(negedge CLK50);
        release_bus();
        for (int i = 0; i < 20 && FCI_OE; i++) @(negedge CLK50);
        repeat (4) @(negedge CLK50);
    endtask

    task automatic abort_pulse();
        FWR_N = 1'b0; FIORQ_N = 1'b0;
        repeat (3) @(negedge CLK50);
        release_bus();
        repeat (4) @(negedge CLK50);
        exp_abort = (exp_abort < 255) ? exp_abort + 1 : 255;
    endtask

    initial begin
        bit ok;
        int dly;
        repeat (3) @(negedge CLK50);
        check("rst_fci_oe", 32'(FCI_OE), 32'd0);
        check("rst_fdir", 32'(FDIR), 32'd1);
        check("rst_fci_s", 32'(FCI_S), 32'd0);
        check("rst_req", 32'(req), 32'd0);
        check("rst_req_addr", 32'(req_addr), 32'd0);
        check("rst_req_wdata", 32'(req_wdata), 32'd0);
        check("rst_req_we_io", 32'({req_we, req_io}), 32'd0);
        check("rst_abort_cnt", 32'(abort_cnt), 32'd0);
        check("rst_fci_o", 32'(FCI_O), 32'd0);
        RST = 1'b0;
        repeat (3) @(negedge CLK50);

        // OUT (#FE),#5A
        bus_write(16'h12FE, 8'h5A, 1'b1, 4);
        check("abort_cnt_after_write", 32'(abort_cnt), 32'(exp_abort));
        // memory read answered 4 cycles after req
        bus_read(16'h8001, 1'b0, 4, 8'hC3);
        // IO read with no answer
        bus_read(16'($urandom), 1'b1, -1, 8'h00);
        // back-to-back writes, 2 idle cycles apart
        bus_write(16'($urandom), 8'($urandom), 1'b0, 2);
        bus_write(16'($urandom), 8'($urandom), 1'b1, 4);

        // short write strobes abort
        abort_pulse();
        repeat (2) @(negedge CLK50);
        check("abort_cnt_one", 32'(abort_cnt), 32'(exp_abort));
        for (int i = 0; i < 299; i++) abort_pulse();
        repeat (2) @(negedge CLK50);
        check("abort_cnt_saturated", 32'(abort_cnt), 32'(exp_abort));

        // randomized mix
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 0)
                bus_write(16'($urandom), 8'($urandom), 1'($urandom), 2 + $urandom_range(0, 3));
            else begin
                dly = $urandom_range(0, 11);
                if (dly == 11) dly = -1;
                bus_read(16'($urandom), 1'($urandom), dly, 8'($urandom));
            end
        end

        // reset while a read is being driven
        bus_addr = 16'h4321;
        FRD_N = 1'b0; FMRQ_N = 1'b0;
        exp_q.push_back('{16'h4321, 8'h00, 1'b0, 1'b0, cyc, LAT_RD});
        rd_q.push_back(8'h96);
        tmo_q.push_back(1'b0);
        wait_req(ok);
        rd_data = 8'h96; rd_valid = 1'b1;
        @(negedge CLK50);
        rd_valid = 1'b0;
        for (int i = 0; i < 20 && !FCI_OE; i++) @(negedge CLK50);
        if (!FCI_OE) fail_now("oe_timeout_rst");
        #2 RST = 1'b1;
        #1;
        check("rst_async_fci_oe", 32'(FCI_OE), 32'd0);
        check("rst_async_fdir", 32'(FDIR), 32'd1);
        release_bus();
        exp_abort = 0;
        @(negedge CLK50);
        @(negedge CLK50);
        RST = 1'b0;
        check("abort_cnt_after_rst", 32'(abort_cnt), 32'(exp_abort));
        @(negedge CLK50);
        bus_write(16'hBEEF, 8'hA5, 1'b0, 4);

        repeat (10) @(negedge CLK50);
        check("req_queue_drained", 32'(exp_q.size()), 32'd0);
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected end of stimulus");
        $fatal(1, "watchdog");
    end

endmodule
